// File: rtl/alu_rs_scheduler_pkg.sv
// Shared CPU defines for the ALU reservation station: default sizes, the op map
// subset used by the integer ALU, and the operand snoop helper.
package alu_rs_scheduler_pkg;

    localparam int RS_SIZE_DEFAULT = 16;
    localparam int ROB_W_DEFAULT   = 4;
    localparam int OP_W            = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
    localparam logic [OP_W-1:0] OP_AND  = 6'd2;
    localparam logic [OP_W-1:0] OP_OR   = 6'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 6'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 6'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 6'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 6'd9;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd10;
    localparam logic [OP_W-1:0] OP_BNE  = 6'd11;
    localparam logic [OP_W-1:0] OP_BLT  = 6'd12;
    localparam logic [OP_W-1:0] OP_BGE  = 6'd13;
    localparam logic [OP_W-1:0] OP_BLTU = 6'd14;
    localparam logic [OP_W-1:0] OP_BGEU = 6'd15;

    typedef struct packed {
        logic        pend;
        logic [31:0] val;
    } operand_t;

    // ALU broadcast takes precedence when both buses carry the awaited tag.
    function automatic operand_t snoop(input operand_t cur,
                                       input logic alu_hit, input logic [31:0] alu_val,
                                       input logic lsb_hit, input logic [31:0] lsb_val);
        operand_t r;
        r = cur;
        if (cur.pend && alu_hit) begin
            r.pend = 1'b0;
            r.val  = alu_val;
        end else if (cur.pend && lsb_hit) begin
            r.pend = 1'b0;
            r.val  = lsb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_rs_select.sv
// Parameterised lowest-index priority picker: one-hot grant, binary index and a found flag.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU/branch reservation station: captures operands from ALU/LSB broadcasts and issues one
// ready entry per cycle. Define RS_AGE_PRIORITY_EN for oldest-first issue via an age matrix.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT,
    parameter int ROB_W   = ROB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_opcode_id,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [31:0]      disp_A,
    input  logic [ROB_W-1:0] disp_ROB_pos,
    output logic             rs_full,
    input  logic             alu_res_valid,
    input  logic [ROB_W-1:0] alu_res_pos,
    input  logic [31:0]      alu_res_val,
    input  logic             lsb_res_valid,
    input  logic [ROB_W-1:0] lsb_res_pos,
    input  logic [31:0]      lsb_res_val,
    output logic             issue_valid,
    output logic [OP_W-1:0]  issue_opcode_id,
    output logic [31:0]      issue_vj,
    output logic [31:0]      issue_vk,
    output logic [31:0]      issue_A,
    output logic [ROB_W-1:0] issue_ROB_pos
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_busy;
    logic [RS_SIZE-1:0] qk_busy;
    logic [OP_W-1:0]    op_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        a_q   [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] free_grant;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [RS_SIZE-1:0] issue_grant;
    logic [IDX_W-1:0]   issue_idx;
    logic               issue_found;
    logic               accept;
    operand_t           wj [RS_SIZE];
    operand_t           wk [RS_SIZE];
    operand_t           dj;
    operand_t           dk;

    // Dispatch handshake: disp_valid is taken on an rdy edge when !rs_full and !flush;
    // there is no hold, so upstream must stall on rs_full. issue_valid is a one-cycle
    // pulse with no back-pressure because the ALU always accepts.
    assign rs_full = &busy;
    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign accept  = rdy && disp_valid && !rs_full && !flush && free_found;

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_select (
        .req   (~busy),
        .grant (free_grant),
        .idx   (free_idx),
        .found (free_found)
    );

`ifdef RS_AGE_PRIORITY_EN
    // older[i][j] = 1 when entry j was dispatched before entry i.
    logic [RS_SIZE-1:0] older [RS_SIZE];

    always_comb begin
        issue_grant = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && ((ready & older[i]) == '0)) begin
                issue_grant[i] = 1'b1;
                issue_idx      = IDX_W'(i);
                issue_found    = 1'b1;
            end
        end
    end
`else
    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_select (
        .req   (ready),
        .grant (issue_grant),
        .idx   (issue_idx),
        .found (issue_found)
    );
`endif

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wj[i] = snoop(operand_t'{qj_busy[i], vj_q[i]},
                          alu_res_valid && (alu_res_pos == qj_q[i]), alu_res_val,
                          lsb_res_valid && (lsb_res_pos == qj_q[i]), lsb_res_val);
            wk[i] = snoop(operand_t'{qk_busy[i], vk_q[i]},
                          alu_res_valid && (alu_res_pos == qk_q[i]), alu_res_val,
                          lsb_res_valid && (lsb_res_pos == qk_q[i]), lsb_res_val);
        end
        dj = snoop(operand_t'{disp_qj_busy, disp_vj},
                   alu_res_valid && (alu_res_pos == disp_qj), alu_res_val,
                   lsb_res_valid && (lsb_res_pos == disp_qj), lsb_res_val);
        dk = snoop(operand_t'{disp_qk_busy, disp_vk},
                   alu_res_valid && (alu_res_pos == disp_qk), alu_res_val,
                   lsb_res_valid && (lsb_res_pos == disp_qk), lsb_res_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy            <= '0;
            qj_busy         <= '0;
            qk_busy         <= '0;
            issue_valid     <= 1'b0;
            issue_opcode_id <= '0;
            issue_vj        <= '0;
            issue_vk        <= '0;
            issue_A         <= '0;
            issue_ROB_pos   <= '0;
`ifdef RS_AGE_PRIORITY_EN
            for (int r = 0; r < RS_SIZE; r++) older[r] <= '0;
`endif
        end else if (rdy) begin
            if (flush) begin
                busy            <= '0;
                issue_valid     <= 1'b0;
                issue_opcode_id <= '0;
                issue_vj        <= '0;
                issue_vk        <= '0;
                issue_A         <= '0;
                issue_ROB_pos   <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        qj_busy[i] <= wj[i].pend;
                        qk_busy[i] <= wk[i].pend;
                    end
                end
                if (issue_found) begin
                    issue_valid     <= 1'b1;
                    issue_opcode_id <= op_q[issue_idx];
                    issue_vj        <= vj_q[issue_idx];
                    issue_vk        <= vk_q[issue_idx];
                    issue_A         <= a_q[issue_idx];
                    issue_ROB_pos   <= rob_q[issue_idx];
                end else begin
                    issue_valid     <= 1'b0;
                    issue_opcode_id <= '0;
                    issue_vj        <= '0;
                    issue_vk        <= '0;
                    issue_A         <= '0;
                    issue_ROB_pos   <= '0;
                end
                busy <= (busy & ~issue_grant) | (accept ? free_grant : '0);
                if (accept) begin
                    qj_busy[free_idx] <= dj.pend;
                    qk_busy[free_idx] <= dk.pend;
`ifdef RS_AGE_PRIORITY_EN
                    for (int r = 0; r < RS_SIZE; r++) older[r][free_idx] <= 1'b0;
                    older[free_idx] <= busy;
`endif
                end
            end
        end
    end

    // Payload carries no reset; busy qualifies every field.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    vj_q[i] <= wj[i].val;
                    vk_q[i] <= wk[i].val;
                end
            end
            if (accept) begin
                op_q[free_idx]  <= disp_opcode_id;
                qj_q[free_idx]  <= disp_qj;
                qk_q[free_idx]  <= disp_qk;
                vj_q[free_idx]  <= dj.val;
                vk_q[free_idx]  <= dk.val;
                a_q[free_idx]   <= disp_A;
                rob_q[free_idx] <= disp_ROB_pos;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed and randomized bench for alu_rs_scheduler against a slot/sequence-number
// reference model of the reservation station.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int N = 16;

    logic        clk, rst, rdy, flush;
    logic        disp_valid, disp_qj_busy, disp_qk_busy;
    logic [5:0]  disp_opcode_id;
    logic [3:0]  disp_qj, disp_qk, disp_ROB_pos;
    logic [31:0] disp_vj, disp_vk, disp_A;
    logic        rs_full;
    logic        alu_res_valid, lsb_res_valid;
    logic [3:0]  alu_res_pos, lsb_res_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        issue_valid;
    logic [5:0]  issue_opcode_id;
    logic [31:0] issue_vj, issue_vk, issue_A;
    logic [3:0]  issue_ROB_pos;

    alu_rs_scheduler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_opcode_id(disp_opcode_id),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_A(disp_A),
        .disp_ROB_pos(disp_ROB_pos), .rs_full(rs_full),
        .alu_res_valid(alu_res_valid), .alu_res_pos(alu_res_pos), .alu_res_val(alu_res_val),
        .lsb_res_valid(lsb_res_valid), .lsb_res_pos(lsb_res_pos), .lsb_res_val(lsb_res_val),
        .issue_valid(issue_valid), .issue_opcode_id(issue_opcode_id),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_A(issue_A),
        .issue_ROB_pos(issue_ROB_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents plus a dispatch sequence number for age.
    bit          m_valid [N];
    bit          m_jb [N], m_kb [N];
    logic [5:0]  m_op [N];
    logic [3:0]  m_qj [N], m_qk [N], m_pos [N];
    logic [31:0] m_vj [N], m_vk [N], m_a [N];
    int          m_seq [N];
    int          seq_ctr = 0;
    bit          e_iv;
    logic [5:0]  e_iop;
    logic [31:0] e_ivj, e_ivk, e_ia;
    logic [3:0]  e_ipos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        e_iv = 0; e_iop = 0; e_ivj = 0; e_ivk = 0; e_ia = 0; e_ipos = 0;
    endtask

    task automatic resolve(input bit b, input logic [3:0] tag, input logic [31:0] v,
                           output bit ob, output logic [31:0] ov);
        ob = b; ov = v;
        if (b && alu_res_valid && alu_res_pos == tag) begin ob = 0; ov = alu_res_val; end
        else if (b && lsb_res_valid && lsb_res_pos == tag) begin ob = 0; ov = lsb_res_val; end
    endtask

    task automatic model_edge();
        int sel, fslot;
        bit full;
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            e_iv = 0; e_iop = 0; e_ivj = 0; e_ivk = 0; e_ia = 0; e_ipos = 0;
            return;
        end
        sel = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && !m_jb[i] && !m_kb[i]) begin
`ifdef RS_AGE_PRIORITY_EN
                if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        if (sel >= 0) begin
            e_iv = 1; e_iop = m_op[sel]; e_ivj = m_vj[sel]; e_ivk = m_vk[sel];
            e_ia = m_a[sel]; e_ipos = m_pos[sel];
        end else begin
            e_iv = 0; e_iop = 0; e_ivj = 0; e_ivk = 0; e_ia = 0; e_ipos = 0;
        end
        full = m_full();
        fslot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) fslot = i;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) begin
                resolve(m_jb[i], m_qj[i], m_vj[i], m_jb[i], m_vj[i]);
                resolve(m_kb[i], m_qk[i], m_vk[i], m_kb[i], m_vk[i]);
            end
        end
        if (disp_valid && !full) begin
            m_valid[fslot] = 1; m_op[fslot] = disp_opcode_id;
            m_qj[fslot] = disp_qj; m_qk[fslot] = disp_qk;
            resolve(disp_qj_busy, disp_qj, disp_vj, m_jb[fslot], m_vj[fslot]);
            resolve(disp_qk_busy, disp_qk, disp_vk, m_kb[fslot], m_vk[fslot]);
            m_a[fslot] = disp_A; m_pos[fslot] = disp_ROB_pos;
            m_seq[fslot] = seq_ctr++;
        end
        if (sel >= 0) m_valid[sel] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, issue_valid, e_iv);
        chk({tag, ".op"}, issue_opcode_id, e_iop);
        chk({tag, ".vj"}, issue_vj, e_ivj);
        chk({tag, ".vk"}, issue_vk, e_ivk);
        chk({tag, ".a"}, issue_A, e_ia);
        chk({tag, ".pos"}, issue_ROB_pos, e_ipos);
        chk({tag, ".full"}, rs_full, m_full());
    endtask

    task automatic step(input string tag);
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        disp_valid = 0; disp_opcode_id = 0; disp_qj_busy = 0; disp_qk_busy = 0;
        disp_qj = 0; disp_qk = 0; disp_vj = 0; disp_vk = 0; disp_A = 0; disp_ROB_pos = 0;
        alu_res_valid = 0; alu_res_pos = 0; alu_res_val = 0;
        lsb_res_valid = 0; lsb_res_pos = 0; lsb_res_val = 0;
        flush = 0; rdy = 1;
    endtask

    task automatic drive_disp(input logic [5:0] op, input bit jb, input logic [3:0] qj,
                              input logic [31:0] vj, input bit kb, input logic [3:0] qk,
                              input logic [31:0] vk, input logic [31:0] a, input logic [3:0] pos);
        disp_valid = 1; disp_opcode_id = op; disp_qj_busy = jb; disp_qj = qj; disp_vj = vj;
        disp_qk_busy = kb; disp_qk = qk; disp_vk = vk; disp_A = a; disp_ROB_pos = pos;
    endtask

    task automatic bcast_alu(input logic [3:0] pos, input logic [31:0] val);
        alu_res_valid = 1; alu_res_pos = pos; alu_res_val = val;
    endtask

    task automatic bcast_lsb(input logic [3:0] pos, input logic [31:0] val);
        lsb_res_valid = 1; lsb_res_pos = pos; lsb_res_val = val;
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        step("reset0");
        step("reset1");
        chk("reset_valid", issue_valid, 0);
        chk("reset_full", rs_full, 0);
        rst = 0;

        // Ready dispatch: ADD 5+7 to ROB 3
        drive_disp(OP_ADD, 0, 0, 5, 0, 0, 7, 0, 3);
        step("add_disp");
        chk("add_wait", issue_valid, 0);
        idle();
        step("add_issue");
        chk("add_valid", issue_valid, 1);
        chk("add_op", issue_opcode_id, OP_ADD);
        chk("add_pos", issue_ROB_pos, 3);
        chk("add_sum", issue_vj + issue_vk, 12);

        // Same-cycle LSB bypass on dispatch, then ALU wakeup of a second entry
        drive_disp(OP_SUB, 1, 2, 0, 0, 0, 1, 0, 5);
        bcast_lsb(2, 100);
        step("sub_disp");
        idle();
        drive_disp(OP_AND, 1, 4, 0, 0, 0, 3, 0, 6);
        step("sub_issue");
        chk("sub_op", issue_opcode_id, OP_SUB);
        chk("sub_vj", issue_vj, 100);
        idle();
        bcast_alu(4, 32'h55);
        step("and_wake");
        chk("and_wait", issue_valid, 0);
        idle();
        step("and_issue");
        chk("and_vj", issue_vj, 32'h55);
        chk("and_pos", issue_ROB_pos, 6);

        // Full boundary: 16 pending entries, 17th dropped
        for (int i = 0; i < N; i++) begin
            drive_disp(OP_OR, 1, (i == 7) ? 4'd10 : 4'd9, 0, 0, 0, i, 0, 4'(i));
            step("fill");
        end
        chk("full_set", rs_full, 1);
        drive_disp(OP_XOR, 0, 0, 1, 0, 0, 1, 0, 15);
        step("drop");
        chk("drop_full", rs_full, 1);
        idle();
        bcast_alu(10, 32'h77);
        step("full_wake");
        chk("full_wake_full", rs_full, 1);
        idle();
        step("full_issue");
        chk("full_issue_valid", issue_valid, 1);
        chk("full_issue_pos", issue_ROB_pos, 7);
        chk("full_issue_vj", issue_vj, 32'h77);
        chk("full_clear", rs_full, 0);
        step("full_after");
        chk("drop_not_kept", issue_valid, 0);

        // Flush with simultaneous dispatch
        drive_disp(OP_ADD, 0, 0, 1, 0, 0, 1, 0, 2);
        flush = 1;
        step("flush");
        chk("flush_valid", issue_valid, 0);
        chk("flush_full", rs_full, 0);
        idle();
        step("flush_after");
        chk("flush_empty", issue_valid, 0);

        // Age priority: A in slot 5 (ROB 10), B in slot 2 (ROB 11), both wait on tag 1
        for (int i = 0; i < 6; i++) begin
            drive_disp(OP_ADD, 1, (i == 2) ? 4'd13 : ((i == 5) ? 4'd1 : 4'd14), 0,
                       0, 0, 0, 0, (i == 5) ? 4'd10 : 4'(i));
            step("prio_fill");
        end
        idle();
        bcast_lsb(13, 9);
        step("prio_wake2");
        idle();
        step("prio_issue2");
        chk("prio_issue2_pos", issue_ROB_pos, 2);
        drive_disp(OP_SUB, 1, 1, 0, 0, 0, 0, 0, 11);
        step("prio_disp_b");
        idle();
        bcast_alu(1, 32'h1234);
        step("prio_wake");
        idle();
        step("prio_first");
`ifdef RS_AGE_PRIORITY_EN
        chk("prio_first_pos", issue_ROB_pos, 10);
`else
        chk("prio_first_pos", issue_ROB_pos, 11);
`endif
        step("prio_second");
`ifdef RS_AGE_PRIORITY_EN
        chk("prio_second_pos", issue_ROB_pos, 11);
`else
        chk("prio_second_pos", issue_ROB_pos, 10);
`endif
        chk("prio_second_vj", issue_vj, 32'h1234);
        flush = 1;
        step("prio_flush");
        idle();

        // rdy low: outputs hold, dispatch ignored, pending entry issues on resume
        drive_disp(OP_ADD, 0, 0, 3, 0, 0, 4, 0, 7);
        step("rdy_disp_x");
        drive_disp(OP_ADD, 0, 0, 8, 0, 0, 9, 0, 8);
        step("rdy_issue_x");
        chk("rdy_x_pos", issue_ROB_pos, 7);
        drive_disp(OP_XOR, 0, 0, 1, 0, 0, 1, 0, 9);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step("rdy_hold");
            chk("rdy_hold_valid", issue_valid, 1);
            chk("rdy_hold_pos", issue_ROB_pos, 7);
        end
        idle();
        step("rdy_resume");
        chk("rdy_resume_pos", issue_ROB_pos, 8);
        step("rdy_empty");
        chk("rdy_no_stall_disp", issue_valid, 0);

        // Asynchronous reset mid-operation
        drive_disp(OP_OR, 1, 3, 0, 0, 0, 0, 0, 0);
        step("mr_fill0");
        drive_disp(OP_OR, 0, 0, 1, 0, 0, 2, 0, 1);
        step("mr_fill1");
        drive_disp(OP_OR, 1, 3, 0, 0, 0, 0, 0, 2);
        step("mr_fill2");
        chk("mr_pre_valid", issue_valid, 1);
        idle();
        #3;
        rst = 1;
        model_reset();
        #1;
        chk("mr_valid", issue_valid, 0);
        chk("mr_full", rs_full, 0);
        step("mr_hold");
        rst = 0;
        bcast_alu(3, 5);
        step("mr_release");
        idle();
        step("mr_after");
        chk("mr_no_issue", issue_valid, 0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            disp_valid = $urandom_range(0, 1);
            disp_opcode_id = 6'($urandom_range(0, 15));
            disp_qj_busy = ($urandom_range(0, 2) == 0);
            disp_qk_busy = ($urandom_range(0, 2) == 0);
            disp_qj = 4'($urandom_range(0, 15));
            disp_qk = 4'($urandom_range(0, 15));
            disp_vj = $urandom;
            disp_vk = $urandom;
            disp_A = $urandom;
            disp_ROB_pos = 4'($urandom_range(0, 15));
            alu_res_valid = $urandom_range(0, 1);
            alu_res_pos = 4'($urandom_range(0, 15));
            alu_res_val = $urandom;
            lsb_res_valid = $urandom_range(0, 1);
            lsb_res_pos = 4'($urandom_range(0, 15));
            lsb_res_val = $urandom;
            step("rand");
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation-station scheduler for the integer ALU. It holds dispatched ALU and branch micro-ops until both operands are available. It captures operand values from the ALU and LSB result broadcasts, and issues at most one ready entry per cycle into the combinational ALU through registered issue outputs. It sits between the dispatch stage and the ALU; the ALU result returns to this block for wakeup and goes on to the ROB.

## Interface
- RS_SIZE, 16, number of entries (power of two, ≥2)
- ROB_W, 4, ROB index width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction clear
- disp_valid  in  1  dispatch request
- disp_opcode_id  in  6  opcode from shared op map
- disp_qj_busy / disp_qk_busy  in  1 each  operand j/k still pending
- disp_qj / disp_qk  in  ROB_W each  producer ROB tag
- disp_vj / disp_vk / disp_A  in  32 each  operand values, immediate
- disp_ROB_pos  in  ROB_W  destination ROB slot
- rs_full  out  1  no free entry
- alu_res_valid / alu_res_pos / alu_res_val  in  1/ROB_W/32  ALU broadcast (fed back)
- lsb_res_valid / lsb_res_pos / lsb_res_val  in  1/ROB_W/32  LSB broadcast
- issue_valid  out  1  to ALU instr_valid
- issue_opcode_id  out  6
- issue_vj / issue_vk / issue_A  out  32 each
- issue_ROB_pos  out  ROB_W

## Operation
- Entry fields: busy, opcode, qj_busy, qj, vj, qk_busy, qk, vk, A, ROB_pos.
- Dispatch (disp_valid, !rs_full, !flush): write the lowest-index free slot.
  - If a pending tag matches a same-cycle valid broadcast, store the value and clear the busy flag (bypass).
  - If both broadcasts match the same tag, ALU has priority.
- Wakeup: on every edge, each busy entry with a pending operand whose tag equals a valid broadcast captures the value and clears the flag. j and k are checked independently.
- Ready = busy & !qj_busy & !qk_busy, evaluated on registered state. A value captured this edge makes the entry eligible next cycle.
- Select: one ready entry per cycle. Its fields load into the issue registers and issue_valid=1. The slot is freed on the same edge. With no ready entry, issue_valid=0 and the other issue outputs hold 0.
- rs_full = all RS_SIZE entries busy (registered-state, combinational output). A slot freed by issue becomes usable next cycle. Dispatch while full is dropped; upstream must stall.
- flush: on the edge, clear every busy bit and issue_valid, and zero the issue outputs. flush wins over dispatch, issue and wakeup.
- rdy low: no state changes. The issue registers hold, so the ALU output repeats; the whole core is stalled on rdy.
- rst: all busy bits 0, issue_valid 0, all issue outputs 0, age matrix 0. rs_full = 0.

## Timing
- Dispatch with ready operands at edge t → issued at edge t+1 → ALU result valid in cycle after t+1 (2-cycle minimum dispatch-to-result).
- Back-to-back dependent ops: the producer's result broadcasts in cycle c and the consumer captures it at edge c. The consumer issues at edge c+1, so dependent issue is every other cycle.
- Throughput: one issue per cycle; one dispatch per cycle.

## Configuration
- RS_AGE_PRIORITY_EN defined: oldest-first selection via an RS_SIZE×RS_SIZE age matrix.
  - On dispatch to slot i, row i = the current busy vector (older set), and column i is cleared in all rows.
  - Selected = ready i with no ready j where older[i][j]=1.
- Undefined: lowest-index ready entry wins; no age matrix storage.
- Free-slot choice is lowest-index in both modes.

## Structure
- Opcode defines (ADD…BGEU) come from the shared op map include.
- RS_SIZE default and the ROB_W constant belong in the shared CPU defines package.
- One sub-module, rs_select: a parameterised priority picker returning one-hot grant and index. It is instantiated twice: for free-slot choice and, without RS_AGE_PRIORITY_EN, for issue choice.

## Test plan
- Reset mid-operation: 3 busy entries, assert rst → issue_valid=0 and rs_full=0 immediately; no issue after release.
- Ready dispatch: ADD vj=5, vk=7, ROB_pos=3 at edge t → issue_valid=1, opcode ADD, ROB_pos=3 after edge t+1; ALU_val=12.
- Wakeup and bypass:
  - Dispatch SUB with qj=2 pending while lsb_res_valid pos=2 val=100 in the same cycle → captured; issues next edge with vj=100.
  - A second entry waiting on tag 4 wakes when alu_res pos=4.
- Full boundary: fill 16 entries, all pending → rs_full=1; a 17th dispatch is dropped. Wake one entry → it issues, and rs_full=0 the next cycle.
- Priority (with RS_AGE_PRIORITY_EN): dispatch A into slot 5, then B into slot 2, both waiting on tag 1; broadcast tag 1 → A issues first, B on the following cycle. Without the macro, B issues first.
- Flush plus rdy:
  - flush with simultaneous disp_valid → the RS is empty after the edge and issue_valid=0.
  - rdy=0 for 3 cycles with a ready entry → no issue and outputs held; the entry issues on the first rdy=1 edge.
